// File: rtl/ascii_tile_mapper_pkg.sv
// ascii_pkg: shared state type, ASCII ramp and default geometry constants
// for the ascii_tile_mapper block.
package ascii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Default 640x480 frame cut into 8x8 tiles.
  localparam int TILES_X  = 80;
  localparam int TILES_Y  = 60;
  localparam int TILE_PIX = 64;
  localparam int SUM_W    = 10;

  // Darkest to brightest: " .,:-=+*ox%#&$W@"
  localparam logic [7:0] RAMP [16] = '{
    8'h20, 8'h2E, 8'h2C, 8'h3A, 8'h2D, 8'h3D, 8'h2B, 8'h2A,
    8'h6F, 8'h78, 8'h25, 8'h23, 8'h26, 8'h24, 8'h57, 8'h40
  };

  function automatic logic [7:0] ramp_char(input logic [3:0] idx);
    return RAMP[idx];
  endfunction

endpackage

// File: rtl/ascii_tile_mapper_tile_addr_gen.sv
// tile_addr_gen: walks the frame buffer tile by tile (px fastest, then py,
// then tiles in raster order) and keeps a running read address so no
// multiplier is needed. The address only moves when the next read is issued,
// so it holds the last issued address while the reader is idle.
module tile_addr_gen
  import ascii_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int TILE_W = 8,
  parameter int TILE_H = 8,
  parameter int TX_N   = TILES_X,
  parameter int TY_N   = TILES_Y,
  parameter int FB_AW  = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [FB_AW-1:0] fb_addr_o,
  output logic             last_pix_o,
  output logic             last_tile_o
);

  localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int TXW = (TX_N > 1) ? $clog2(TX_N) : 1;
  localparam int TYW = (TY_N > 1) ? $clog2(TY_N) : 1;
  // From the last pixel of a tile row to the first pixel of the next row.
  localparam logic [FB_AW-1:0] ROW_STEP  = FB_AW'(IMG_W - TILE_W + 1);
  // Tile origin to the next tile origin on the same band.
  localparam logic [FB_AW-1:0] TILE_STEP = FB_AW'(TILE_W);
  // Origin of the last tile in a band to the first tile of the next band.
  localparam logic [FB_AW-1:0] BAND_STEP = FB_AW'(TILE_H * IMG_W - (TX_N - 1) * TILE_W);

  logic [PXW-1:0]   px_q, px_d;
  logic [PYW-1:0]   py_q, py_d;
  logic [TXW-1:0]   tx_q, tx_d;
  logic [TYW-1:0]   ty_q, ty_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic [FB_AW-1:0] base_q, base_d;
  logic             end_px, end_py, end_tx, end_ty;

  assign end_px      = (px_q == PXW'(TILE_W - 1));
  assign end_py      = (py_q == PYW'(TILE_H - 1));
  assign end_tx      = (tx_q == TXW'(TX_N - 1));
  assign end_ty      = (ty_q == TYW'(TY_N - 1));
  assign last_pix_o  = end_px && end_py;
  assign last_tile_o = end_tx && end_ty;
  assign fb_addr_o   = addr_q;

  // Next position: restart at frame origin, or step one pixel forward.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    tx_d   = tx_q;
    ty_d   = ty_q;
    addr_d = addr_q;
    base_d = base_q;
    if (clear_i) begin
      px_d   = '0;
      py_d   = '0;
      tx_d   = '0;
      ty_d   = '0;
      addr_d = '0;
      base_d = '0;
    end else if (adv_i) begin
      if (!end_px) begin
        px_d   = px_q + PXW'(1);
        addr_d = addr_q + FB_AW'(1);
      end else if (!end_py) begin
        px_d   = '0;
        py_d   = py_q + PYW'(1);
        addr_d = addr_q + ROW_STEP;
      end else begin
        px_d = '0;
        py_d = '0;
        if (!end_tx) begin
          tx_d   = tx_q + TXW'(1);
          base_d = base_q + TILE_STEP;
        end else begin
          tx_d   = '0;
          ty_d   = ty_q + TYW'(1);
          base_d = base_q + BAND_STEP;
        end
        addr_d = base_d;
      end
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q   <= '0;
      py_q   <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/ascii_tile_mapper.sv
// ascii_tile_mapper: averages each tile of the luma frame buffer and writes
// one ASCII ramp character per tile into the character buffer.
// Optional build macro ASCII_TILE_INVERT_EN: reverses the ramp index
// (15 - luma) for dark-on-light displays.
module ascii_tile_mapper
  import ascii_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int TILE_W = 8,
  parameter int TILE_H = 8,
  parameter int RD_LAT = 1,
  parameter int FB_AW  = 19,
  parameter int PIX_W  = 4,
  parameter int CH_AW  = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fb_rd,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [PIX_W-1:0] fb_data,
  output logic             char_we,
  output logic [CH_AW-1:0] char_addr,
  output logic [7:0]       char_data
);

  localparam int TX_N     = IMG_W / TILE_W;
  localparam int TY_N     = IMG_H / TILE_H;
  localparam int N_PIX    = TILE_W * TILE_H;
  localparam int LOG2_PIX = $clog2(N_PIX);
  localparam int SW       = $clog2(N_PIX * ((1 << PIX_W) - 1) + 1);
  localparam int DW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e           state_q, state_d;
  logic [RD_LAT-1:0] vld_q;
  logic [SW-1:0]    sum_q, sum_d, acc_sum;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CH_AW-1:0] tile_q, tile_d;
  logic [CH_AW-1:0] char_addr_q, char_addr_d;
  logic [7:0]       char_data_q, char_data_d;
  logic             gen_clear, gen_adv, last_pix, last_tile;
  logic [3:0]       luma, ramp_idx;

  tile_addr_gen #(
    .IMG_W (IMG_W),
    .TILE_W(TILE_W),
    .TILE_H(TILE_H),
    .TX_N  (TX_N),
    .TY_N  (TY_N),
    .FB_AW (FB_AW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (gen_clear),
    .adv_i      (gen_adv),
    .fb_addr_o  (fb_addr),
    .last_pix_o (last_pix),
    .last_tile_o(last_tile)
  );

  // The delayed read strobe marks cycles where fb_data belongs to the tile.
  assign acc_sum = vld_q[RD_LAT-1] ? (sum_q + SW'(fb_data)) : sum_q;
  assign luma    = 4'(acc_sum >> LOG2_PIX);

`ifdef ASCII_TILE_INVERT_EN
  assign ramp_idx = 4'd15 - luma;
`else
  assign ramp_idx = luma;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fb_rd     = (state_q == READ);
  assign char_we   = (state_q == WRITE);
  assign char_addr = char_addr_q;
  assign char_data = char_data_q;

  // Sequencing FSM with accumulator and character/address capture.
  always_comb begin
    state_d     = state_q;
    sum_d       = acc_sum;
    drain_d     = drain_q;
    tile_d      = tile_q;
    char_addr_d = char_addr_q;
    char_data_d = char_data_q;
    gen_clear   = 1'b0;
    gen_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          sum_d     = '0;
          tile_d    = '0;
          gen_clear = 1'b1;
        end
      end
      READ: begin
        if (last_pix) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          gen_adv = 1'b1;
        end
      end
      DRAIN: begin
        // The final pixel lands in the last drain cycle, so the mean is
        // taken from the running sum including it.
        if (drain_q == DW'(RD_LAT - 1)) begin
          state_d     = WRITE;
          char_addr_d = tile_q;
          char_data_d = ramp_char(ramp_idx);
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      WRITE: begin
        if (last_tile) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          sum_d   = '0;
          tile_d  = tile_q + CH_AW'(1);
          gen_adv = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, read-valid pipeline and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      sum_q       <= '0;
      drain_q     <= '0;
      tile_q      <= '0;
      char_addr_q <= '0;
      char_data_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= RD_LAT'({vld_q, fb_rd});
      sum_q       <= sum_d;
      drain_q     <= drain_d;
      tile_q      <= tile_d;
      char_addr_q <= char_addr_d;
      char_data_q <= char_data_d;
    end
  end

endmodule

// File: tb/tb_ascii_tile_mapper.sv
// Scoreboard bench for ascii_tile_mapper on a reduced 80x48 frame
// (10x6 tiles, 60 characters, 66 cycles per tile, 3960 cycles per frame).
module tb_ascii_tile_mapper;

  localparam int W         = 80;
  localparam int H         = 48;
  localparam int TXN       = 10;
  localparam int NT        = 60;
  localparam int TILE_CYC  = 66;
  localparam int FRAME_CYC = 3960;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, fb_rd, char_we;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic [12:0] char_addr;
  logic [7:0]  char_data;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   rd_log[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   wr_cnt     = 0;
  int   done_cnt   = 0;
  int   mode       = 0;
  logic [3:0] uni_val = 4'h0;
  logic [7:0] ramp_exp [16] = '{
    8'h20, 8'h2E, 8'h2C, 8'h3A, 8'h2D, 8'h3D, 8'h2B, 8'h2A,
    8'h6F, 8'h78, 8'h25, 8'h23, 8'h26, 8'h24, 8'h57, 8'h40
  };

  always #5 clk = ~clk;

  ascii_tile_mapper #(
    .IMG_W (W),
    .IMG_H (H),
    .TILE_W(8),
    .TILE_H(8),
    .RD_LAT(1),
    .FB_AW (19),
    .PIX_W (4),
    .CH_AW (13)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fb_rd    (fb_rd),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .char_we  (char_we),
    .char_addr(char_addr),
    .char_data(char_data)
  );

  // Frame content: 0 uniform, 1 ramp 0..15 over each pair of tile rows,
  // 2 per-tile constant (tx+ty)%16.
  function automatic logic [3:0] pix_at(input int a);
    int x, y;
    x = a % W;
    y = a / W;
    case (mode)
      0:       return uni_val;
      1:       return 4'((x % 8) + 8 * (y % 2));
      default: return 4'(((x / 8) + (y / 8)) % 16);
    endcase
  endfunction

  // One-cycle-latency frame-buffer model.
  always @(posedge clk) begin
    if (fb_rd) fb_data <= pix_at(int'(fb_addr));
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per character write.
  always @(negedge clk) begin
    if (char_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(char_addr), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("char_write", int'({char_addr, char_data}), int'({e.addr, e.data}));
        $display("write %0d: addr=%0d data=0x%02h want addr=%0d data=0x%02h",
                 wr_cnt, char_addr, char_data, e.addr, e.data);
      end
    end
    if (done) done_cnt++;
    if (fb_rd) rd_log.push_back(int'(fb_addr));
  end

  task automatic push_frame(input int md, input logic [3:0] v, input int ntiles);
    for (int t = 0; t < ntiles; t++) begin
      logic [3:0] m, idx;
      exp_t e;
      case (md)
        0:       m = v;
        1:       m = 4'd7;            // sum 480 >> 6
        default: m = 4'(((t % TXN) + (t / TXN)) % 16);
      endcase
`ifdef ASCII_TILE_INVERT_EN
      idx = 4'd15 - m;
`else
      idx = m;
`endif
      e.addr = 13'(t);
      e.data = ramp_exp[idx];
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_ctl"}, int'({busy, done, fb_rd, char_we}), 0);
    check({nm, "_fb_addr"}, int'(fb_addr), 0);
    check({nm, "_char_addr"}, int'(char_addr), 0);
    check({nm, "_char_data"}, int'(char_data), 0);
  endtask

  task automatic run_frame(input int md, input logic [3:0] v,
                           input bit extra_start, input int abort_at);
    int n, wr0, dn0;
    bit seen;
    mode    = md;
    uni_val = v;
    rd_log.delete();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    push_frame(md, v, (abort_at >= 0) ? 10 : NT);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (n < FRAME_CYC + 200) begin
      @(posedge clk);
      n++;
      #1;
      start = (extra_start && n == 100);
      if (abort_at >= 0 && n == abort_at) break;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check_idle_outputs("abort");
      repeat (3 * TILE_CYC) @(posedge clk);
      #1;
      check("abort_writes", wr_cnt - wr0, 10);
      check("abort_no_done", done_cnt - dn0, 0);
      check("abort_idle", int'(busy), 0);
    end else begin
      check("done_latency", seen ? n : -1, FRAME_CYC);
      if (extra_start) begin
        start = 1'b1;              // presented during the DONE cycle
        @(posedge clk); #1 start = 1'b0;
      end
      repeat (2 * TILE_CYC) @(posedge clk);
      #1;
      check("idle_after_done", int'(busy), 0);
      check("write_count", wr_cnt - wr0, NT);
      check("done_count", done_cnt - dn0, 1);
      check("char_addr_hold", int'(char_addr), 59);
      check("fb_addr_hold", int'(fb_addr), 3839);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset");

    // Uniform 0xF: brightest ramp entry everywhere.
    run_frame(0, 4'hF, 1'b0, -1);

    // Ramp pattern: mean 7 per tile; also read-address walk.
    run_frame(1, 4'h0, 1'b0, -1);
    for (int i = 0; i < 8; i++)
      check("fb_addr_first_row", (rd_log.size() > i) ? rd_log[i] : -1, i);
    check("fb_addr_9th", (rd_log.size() > 8) ? rd_log[8] : -1, 80);
    check("fb_read_count", rd_log.size(), 3840);
    check("fb_addr_last_tile_first", (rd_log.size() > 3776) ? rd_log[3776] : -1, 3272);
    check("fb_addr_last", (rd_log.size() > 3839) ? rd_log[3839] : -1, 3839);

    // Per-tile levels, with starts while busy and in the DONE cycle.
    run_frame(2, 4'h0, 1'b1, -1);

    // Uniform 0x8 aborted by reset in tile 10, then a clean rerun.
    run_frame(0, 4'h8, 1'b0, 10 * TILE_CYC + 30);
    run_frame(0, 4'h8, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
